alu_mdu: RTL and testbench

//  Parametrised, registered successor of the single-cycle 32-bit ALU for the MIPS datapath.

---
 rtl/alu_mdu_pkg.sv | 25 ++
 rtl/alu_mdu_iter.sv | 73 +++++++
 rtl/alu_mdu.sv | 112 +++++++++++
 tb/tb_alu_mdu.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mdu_pkg.sv
// Shared opcode encodings and FSM states for the registered ALU with iterative MULTU/DIVU.
package alu_mdu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_NOR   = 4'b0010;
  localparam logic [3:0] ALU_ADD   = 4'b0011;
  localparam logic [3:0] ALU_SUB   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLL   = 4'b0110;
  localparam logic [3:0] ALU_SRL   = 4'b0111;
  localparam logic [3:0] ALU_MULTU = 4'b1000;
  localparam logic [3:0] ALU_DIVU  = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  function automatic logic is_multi(input logic [3:0] op);
    return (op == ALU_MULTU) || (op == ALU_DIVU);
  endfunction

endpackage

// File: rtl/alu_mdu_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per step.
// hi/lo present the values after the current step so the top can commit them on the final edge.
module alu_mdu_iter
  import alu_mdu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             finish
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] dvs;
  logic             div_mode;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // NOTE: always_comb uses blocking assignments and assigns every output on every path, so no latch is inferred.
  always_comb begin
    sum     = {1'b0, acc} + (mq[0] ? {1'b0, dvs} : '0);
    shifted = {acc, mq[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    hi      = sum[WIDTH:1];
    lo      = {sum[0], mq[WIDTH-1:1]};
    if (div_mode) begin
      // With a zero divisor every trial subtract succeeds: quotient becomes all ones, remainder becomes a.
      if (shifted >= {1'b0, dvs}) begin
        hi = diff[WIDTH-1:0];
        lo = {mq[WIDTH-2:0], 1'b1};
      end else begin
        hi = shifted[WIDTH-1:0];
        lo = {mq[WIDTH-2:0], 1'b0};
      end
    end
  end

  // NOTE: datapath registers are plain flops with sync reset; sequential state always uses non-blocking <=.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      mq       <= '0;
      dvs      <= '0;
      div_mode <= 1'b0;
      count    <= '0;
    end else if (load) begin
      acc      <= '0;
      mq       <= a;
      dvs      <= b;
      div_mode <= is_div;
      count    <= CW'(WIDTH);
    end else if (step && (count != '0)) begin
      acc   <= hi;
      mq    <= lo;
      count <= count - CW'(1);
    end
  end

  assign finish = step && (count == CW'(1));

endmodule

// File: rtl/alu_mdu.sv
// Registered EX-stage ALU: single-cycle logic/arith/shift ops plus iterative MULTU/DIVU into HI/LO.
// The final mul/div step commits HI/LO on the edge that enters FIN, so done lands WIDTH+1 cycles after start.
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  state_t           state;
  logic [WIDTH-1:0] alu_res;
  logic             dbz_pend;
  logic             accept;
  logic             iter_load;
  logic             iter_finish;
  logic [WIDTH-1:0] iter_hi;
  logic [WIDTH-1:0] iter_lo;

  always_comb begin
    alu_res = '0;
    unique case (alu_op)
      ALU_AND: alu_res = a & b;
      ALU_OR:  alu_res = a | b;
      ALU_NOR: alu_res = ~(a | b);
      ALU_ADD: alu_res = a + b;
      ALU_SUB: alu_res = a - b;
      ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLL: alu_res = b << shamt;
      ALU_SRL: alu_res = b >> shamt;
      default: alu_res = '0;
    endcase
  end

  // FIN behaves like IDLE for new requests, which lets a start in the done cycle be accepted.
  assign accept    = start && (state != RUN);
  assign iter_load = accept && is_multi(alu_op);

  alu_mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .load   (iter_load),
    .step   (state == RUN),
    .is_div (alu_op == ALU_DIVU),
    .a      (a),
    .b      (b),
    .hi     (iter_hi),
    .lo     (iter_lo),
    .finish (iter_finish)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      zero        <= 1'b1;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
      dbz_pend    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, FIN: begin
          state <= IDLE;
          if (accept) begin
            if (is_multi(alu_op)) begin
              state    <= RUN;
              busy     <= 1'b1;
              dbz_pend <= (alu_op == ALU_DIVU) && (b == '0);
            end else begin
              result      <= alu_res;
              zero        <= (alu_res == '0);
              done        <= 1'b1;
              div_by_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          if (iter_finish) begin
            state       <= FIN;
            busy        <= 1'b0;
            done        <= 1'b1;
            hi          <= iter_hi;
            lo          <= iter_lo;
            result      <= iter_lo;
            zero        <= (iter_lo == '0);
            div_by_zero <= dbz_pend;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu (WIDTH=32): directed table, multi-cycle corner sequences, random vs. model.
module tb_alu_mdu;
  import alu_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  alu_op;
  logic [31:0] a, b;
  logic [4:0]  shamt;
  logic        busy, done, zero, div_by_zero;
  logic [31:0] result, hi, lo;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: HI/LO and the divide-by-zero flag as seen by software.
  logic [31:0] m_hi, m_lo;
  logic        m_dbz;

  alu_mdu #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .alu_op      (alu_op),
    .a           (a),
    .b           (b),
    .shamt       (shamt),
    .busy        (busy),
    .done        (done),
    .zero        (zero),
    .result      (result),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] va, vb;
    logic [4:0]  sh;
    logic [31:0] res, ehi, elo;
    logic        dbz;
    bit          chk_hl;
    int          lat;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_op(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                          input logic [4:0] sh, output logic [31:0] res, output int lat);
    logic [63:0] prod;
    lat = 1;
    case (op)
      ALU_AND: res = va & vb;
      ALU_OR:  res = va | vb;
      ALU_NOR: res = ~(va | vb);
      ALU_ADD: res = va + vb;
      ALU_SUB: res = va - vb;
      ALU_SLT: res = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
      ALU_SLL: res = vb << sh;
      ALU_SRL: res = vb >> sh;
      ALU_MULTU: begin
        prod = 64'(va) * 64'(vb);
        m_hi = prod[63:32];
        m_lo = prod[31:0];
        res  = m_lo;
        lat  = 33;
      end
      ALU_DIVU: begin
        m_hi = (vb == 0) ? va : va % vb;
        m_lo = (vb == 0) ? 32'hFFFF_FFFF : va / vb;
        res  = m_lo;
        lat  = 33;
      end
      default: res = 32'd0;
    endcase
    m_dbz = (op == ALU_DIVU) && (vb == 0);
  endtask

  // Called at a negedge; returns at the negedge where done is seen (or after the cycle budget).
  task automatic do_op(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                       input logic [4:0] sh, input bit pulse, output int lat, output int busy_bad);
    alu_op = op;
    a      = va;
    b      = vb;
    shamt  = sh;
    start  = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    lat      = 1;
    busy_bad = 0;
    while (!done && lat < 80) begin
      if (!busy) busy_bad++;
      if (pulse) begin
        start  = 1'b1;
        alu_op = ALU_ADD;
        a      = $urandom;
        b      = $urandom;
      end
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
  endtask

  initial begin
    logic [31:0] eres;
    int          elat, lat, bb;
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    logic [4:0]  rsh;
    bit          seen_done;

    tbl[0]  = '{ALU_ADD,   32'hFFFF_FFFF, 32'h1,         5'd0,  32'h0,         32'h0,         32'h0,         1'b0, 1'b0, 1};
    tbl[1]  = '{ALU_SUB,   32'd5,         32'd5,         5'd0,  32'h0,         32'h0,         32'h0,         1'b0, 1'b0, 1};
    tbl[2]  = '{ALU_SLT,   32'hFFFF_FFFF, 32'h1,         5'd0,  32'h1,         32'h0,         32'h0,         1'b0, 1'b0, 1};
    tbl[3]  = '{ALU_SLL,   32'h0,         32'h1,         5'd31, 32'h8000_0000, 32'h0,         32'h0,         1'b0, 1'b0, 1};
    tbl[4]  = '{ALU_SRL,   32'h0,         32'h8000_0000, 5'd31, 32'h1,         32'h0,         32'h0,         1'b0, 1'b0, 1};
    tbl[5]  = '{ALU_SRL,   32'h0,         32'hA5A5_A5A5, 5'd0,  32'hA5A5_A5A5, 32'h0,         32'h0,         1'b0, 1'b0, 1};
    tbl[6]  = '{ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  32'h1,         32'hFFFF_FFFE, 32'h1,         1'b0, 1'b1, 33};
    tbl[7]  = '{ALU_DIVU,  32'd100,       32'd7,         5'd0,  32'd14,        32'd2,         32'd14,        1'b0, 1'b1, 33};
    tbl[8]  = '{ALU_DIVU,  32'd1234,      32'd0,         5'd0,  32'hFFFF_FFFF, 32'd1234,      32'hFFFF_FFFF, 1'b1, 1'b1, 33};
    tbl[9]  = '{ALU_NOR,   32'h0,         32'h0,         5'd0,  32'hFFFF_FFFF, 32'd1234,      32'hFFFF_FFFF, 1'b0, 1'b1, 1};
    tbl[10] = '{4'b1100,   32'h1234_5678, 32'h9,         5'd3,  32'h0,         32'd1234,      32'hFFFF_FFFF, 1'b0, 1'b1, 1};

    reset  = 1'b1;
    start  = 1'b0;
    alu_op = ALU_AND;
    a      = '0;
    b      = '0;
    shamt  = '0;
    m_hi   = '0;
    m_lo   = '0;
    m_dbz  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 1);
    check("rst_hilo", {hi, lo}, 0);
    check("rst_dbz", div_by_zero, 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed table
    foreach (tbl[i]) begin
      do_op(tbl[i].op, tbl[i].va, tbl[i].vb, tbl[i].sh, 1'b0, lat, bb);
      model_op(tbl[i].op, tbl[i].va, tbl[i].vb, tbl[i].sh, eres, elat);
      check($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
      check($sformatf("tbl%0d_result", i), result, tbl[i].res);
      check($sformatf("tbl%0d_zero", i), zero, tbl[i].res == 0);
      check($sformatf("tbl%0d_dbz", i), div_by_zero, tbl[i].dbz);
      check($sformatf("tbl%0d_busy_done", i), busy, 0);
      if (tbl[i].chk_hl) begin
        check($sformatf("tbl%0d_hi", i), hi, tbl[i].ehi);
        check($sformatf("tbl%0d_lo", i), lo, tbl[i].elo);
      end
      if (tbl[i].lat > 1) check($sformatf("tbl%0d_busy_run", i), bb, 0);
      @(negedge clk);
      check($sformatf("tbl%0d_done_pulse", i), done, 0);
    end

    // Start pulsed every cycle during MULTU is ignored; start in the done cycle is accepted.
    do_op(ALU_MULTU, 32'd12345, 32'd6789, 5'd0, 1'b1, lat, bb);
    model_op(ALU_MULTU, 32'd12345, 32'd6789, 5'd0, eres, elat);
    check("pulse_lat", lat, 33);
    check("pulse_busy", bb, 0);
    check("pulse_hi", hi, 32'd0);
    check("pulse_lo", lo, 32'd83810205);
    do_op(ALU_ADD, 32'd3, 32'd4, 5'd0, 1'b0, lat, bb);
    check("back2back_lat", lat, 1);
    check("back2back_result", result, 32'd7);
    check("back2back_hilo", {hi, lo}, {32'd0, 32'd83810205});
    @(negedge clk);
    check("back2back_done_pulse", done, 0);

    // Reset mid-DIVU aborts it silently and clears HI/LO.
    alu_op = ALU_DIVU;
    a      = 32'hDEAD_BEEF;
    b      = 32'd3;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_busy_before", busy, 1);
    reset     = 1'b1;
    seen_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    reset = 1'b0;
    check("abort_busy", busy, 0);
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    check("abort_no_done", seen_done, 0);
    check("abort_result", result, 0);
    check("abort_zero", zero, 1);
    check("abort_hilo", {hi, lo}, 0);
    m_hi  = '0;
    m_lo  = '0;
    m_dbz = 1'b0;

    // Random ops against the reference model
    for (int n = 0; n < 150; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 300)));
      rsh = 5'($urandom);
      do_op(rop, ra, rb, rsh, 1'($urandom_range(0, 1)), lat, bb);
      model_op(rop, ra, rb, rsh, eres, elat);
      check($sformatf("rnd%0d_op%0h_lat", n, rop), lat, elat);
      check($sformatf("rnd%0d_op%0h_result", n, rop), result, eres);
      check($sformatf("rnd%0d_op%0h_zero", n, rop), zero, eres == 0);
      check($sformatf("rnd%0d_op%0h_hi", n, rop), hi, m_hi);
      check($sformatf("rnd%0d_op%0h_lo", n, rop), lo, m_lo);
      check($sformatf("rnd%0d_op%0h_dbz", n, rop), div_by_zero, m_dbz);
      if (elat > 1) check($sformatf("rnd%0d_busy", n), bb, 0);
      if ($urandom_range(0, 1)) begin
        @(negedge clk);
        check($sformatf("rnd%0d_done_pulse", n), done, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
